vram_write_buffer: RTL and testbench

- Upstream of gpu_m's VRAM write port.
- Accepts CPU-side VRAM writes at any time into a small FIFO.
- Drains the FIFO into the GPU VRAM port (data/address/write_enable) only while the GPU reports vertical blank, so CPU writes never collide with active scan-out.
- Sits between the CPU bus decode and gpu_m, in the same place fill_vram_m occupies in the test configuration.

---
 rtl/vram_write_buffer.sv | 137 +++++++++++++
 tb/tb_vram_write_buffer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_write_buffer.sv
// rtl/vram_write_buffer.sv - CPU-to-VRAM write FIFO drained only during vertical blank
//
// Purpose:
//   Buffers CPU-side VRAM writes in a small circular FIFO and replays them
//   onto the gpu_m VRAM write port only while the GPU is in vertical blank,
//   so CPU writes never collide with active scan-out.
//
// Parameters:
//   ADDR_WIDTH  VRAM address width (must match the GPU's VRAM address width)
//   DEPTH_LOG2  log2 of the FIFO depth
//
// Ports:
//   clk_12_5875        GPU pixel clock, all state on its rising edge
//   rst                asynchronous active-high reset
//   cpu_address/data   CPU write address and data
//   cpu_write          one-cycle write strobe, one write per high cycle
//   in_vblank          GPU vertical-blank status
//   overflow_clr       clears the sticky overflow flag
//   vram_address/data  registered write address/data to gpu_m
//   vram_write_enable  registered one-cycle write strobe to gpu_m
//   full/empty/count   FIFO occupancy status
//   overflow           sticky: a CPU write was dropped
//
// Optional feature (macro VRAM_WBUF_COALESCE_EN):
//   When defined, a write to the same address as the most recently pushed,
//   still-buffered entry overwrites that entry's data in place.

module vram_write_buffer #(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_12_5875,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [7:0]            cpu_data,
  input  logic                  cpu_write,
  input  logic                  in_vblank,
  input  logic                  overflow_clr,
  output logic [ADDR_WIDTH-1:0] vram_address,
  output logic [7:0]            vram_data,
  output logic                  vram_write_enable,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE_CNT   = (DEPTH_LOG2+1)'(1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [7:0]            mem_data [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic                  pop, push, drop, coalesce;

  always_comb begin
    empty = (count == '0);
    full  = (count == DEPTH_CNT);
  end

  // A pop needs the FSM already in DRAIN, so the IDLE->DRAIN edge never pops.
  assign pop = (state == DRAIN) && in_vblank && !empty;

`ifdef VRAM_WBUF_COALESCE_EN
  logic [DEPTH_LOG2-1:0] tail_ptr;
  assign tail_ptr = wptr - DEPTH_LOG2'(1);
  // The tail is being popped only when it is also the head (count == 1).
  assign coalesce = cpu_write && !empty && (mem_addr[tail_ptr] == cpu_address)
                    && !(pop && (count == ONE_CNT));
`else
  assign coalesce = 1'b0;
`endif

  // A same-edge pop frees a slot, so a write into a full FIFO is still accepted.
  assign push = cpu_write && !coalesce && (!full || pop);
  assign drop = cpu_write && !coalesce && full && !pop;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (in_vblank && !empty) next_state = DRAIN;
      end
      DRAIN: begin
        if (!in_vblank || empty)                     next_state = IDLE;
        else if (pop && (count == ONE_CNT) && !push) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Storage is not reset; only the pointers and count define valid entries.
  always_ff @(posedge clk_12_5875) begin
    if (push) begin
      mem_addr[wptr] <= cpu_address;
      mem_data[wptr] <= cpu_data;
    end
`ifdef VRAM_WBUF_COALESCE_EN
    if (coalesce) mem_data[tail_ptr] <= cpu_data;
`endif
  end

  always_ff @(posedge clk_12_5875 or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      wptr              <= '0;
      rptr              <= '0;
      count             <= '0;
      overflow          <= 1'b0;
      vram_write_enable <= 1'b0;
      vram_address      <= '0;
      vram_data         <= '0;
    end else begin
      state <= next_state;
      if (push) wptr <= wptr + DEPTH_LOG2'(1);
      if (pop)  rptr <= rptr + DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
      // A drop on the same edge as overflow_clr leaves the flag set.
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
      vram_write_enable <= pop;
      if (pop) begin
        vram_address <= mem_addr[rptr];
        vram_data    <= mem_data[rptr];
      end
    end
  end

endmodule

// File: tb/tb_vram_write_buffer.sv
// tb/tb_vram_write_buffer.sv - directed self-checking bench for vram_write_buffer

module tb_vram_write_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] cpu_address;
  logic [7:0]  cpu_data;
  logic        cpu_write;
  logic        in_vblank;
  logic        overflow_clr;
  logic [11:0] vram_address;
  logic [7:0]  vram_data;
  logic        vram_write_enable;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic        overflow;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  logic [19:0] wr_q[$];
  int          wr_cyc[$];

  vram_write_buffer #(.ADDR_WIDTH(12), .DEPTH_LOG2(4)) dut (
    .clk_12_5875(clk), .rst(rst), .cpu_address(cpu_address), .cpu_data(cpu_data),
    .cpu_write(cpu_write), .in_vblank(in_vblank), .overflow_clr(overflow_clr),
    .vram_address(vram_address), .vram_data(vram_data),
    .vram_write_enable(vram_write_enable), .full(full), .empty(empty),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vram_write_enable) begin
      wr_q.push_back({vram_address, vram_data});
      wr_cyc.push_back(cyc);
    end
  end

  task automatic push_wr(input logic [11:0] a, input logic [7:0] d);
    cpu_address = a;
    cpu_data    = d;
    cpu_write   = 1'b1;
    @(negedge clk);
    cpu_write   = 1'b0;
  endtask

  task automatic test_reset;
    tests_run++;
    if ({empty, full, count, overflow} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_status: got e=%b f=%b c=%0d o=%b expected e=1 f=0 c=0 o=0", empty, full, count, overflow);
    end
    tests_run++;
    if ({vram_write_enable, vram_address, vram_data} !== 21'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got we=%b a=%h d=%h expected all 0", vram_write_enable, vram_address, vram_data);
    end
  endtask

  task automatic test_basic;
    logic [19:0] exp [3];
    int c0, c1;
    exp[0] = {12'h800, 8'h0F}; exp[1] = {12'h801, 8'h0F}; exp[2] = {12'h803, 8'h07};
    wr_q.delete(); wr_cyc.delete();
    in_vblank = 1'b0;
    for (int i = 0; i < 3; i++) push_wr(exp[i][19:8], exp[i][7:0]);
    repeat (2) @(negedge clk);
    tests_run++;
    if (count !== 5'd3) begin
      tests_failed++;
      $display("FAIL basic_count: got %0d expected 3", count);
    end
    tests_run++;
    if (wr_q.size() != 0) begin
      tests_failed++;
      $display("FAIL basic_no_write_outside_vblank: got %0d writes expected 0", wr_q.size());
    end
    c0 = cyc;
    in_vblank = 1'b1;
    repeat (8) @(negedge clk);
    tests_run++;
    if (wr_q.size() != 3) begin
      tests_failed++;
      $display("FAIL basic_write_count: got %0d expected 3", wr_q.size());
    end
    for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
      tests_run++;
      if (wr_q[i] !== exp[i] || wr_cyc[i] != c0 + 2 + i) begin
        tests_failed++;
        $display("FAIL basic_write%0d: got %h@%0d expected %h@%0d", i, wr_q[i], wr_cyc[i], exp[i], c0 + 2 + i);
      end
    end
    tests_run++;
    if (empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_empty: got %b expected 1", empty);
    end
    // FSM must be back in IDLE: a new write during vblank takes the 2-edge path again.
    wr_q.delete(); wr_cyc.delete();
    c1 = cyc;
    push_wr(12'h8AA, 8'h55);
    repeat (5) @(negedge clk);
    tests_run++;
    if (wr_q.size() != 1 || wr_cyc[0] != c1 + 3 || wr_q[0] !== {12'h8AA, 8'h55}) begin
      tests_failed++;
      $display("FAIL basic_idle_after_empty: got %0d writes first@%0d expected 1 write @%0d", wr_q.size(), (wr_cyc.size() > 0) ? wr_cyc[0] : -1, c1 + 3);
    end
    in_vblank = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_overflow;
    in_vblank = 1'b0;
    for (int i = 0; i < 17; i++) push_wr(12'h100 + 12'(i), 8'(i));
    tests_run++;
    if ({full, count, overflow} !== {1'b1, 5'd16, 1'b1}) begin
      tests_failed++;
      $display("FAIL overflow_set: got f=%b c=%0d o=%b expected f=1 c=16 o=1", full, count, overflow);
    end
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow_clr: got %b expected 0", overflow);
    end
  endtask

  task automatic test_full_drain;
    logic [19:0] e;
    wr_q.delete(); wr_cyc.delete();
    in_vblank = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      cpu_address = 12'h200 + 12'(j);
      cpu_data    = 8'hA0 + 8'(j);
      cpu_write   = 1'b1;
      @(negedge clk);
      tests_run++;
      if (overflow !== 1'b0 || count !== 5'd16) begin
        tests_failed++;
        $display("FAIL full_drain_push%0d: got o=%b c=%0d expected o=0 c=16", j, overflow, count);
      end
    end
    cpu_write = 1'b0;
    repeat (20) @(negedge clk);
    tests_run++;
    if (wr_q.size() != 24) begin
      tests_failed++;
      $display("FAIL full_drain_count: got %0d expected 24", wr_q.size());
    end
    for (int i = 0; i < 24 && i < wr_q.size(); i++) begin
      e = (i < 16) ? {12'h100 + 12'(i), 8'(i)} : {12'h200 + 12'(i - 16), 8'hA0 + 8'(i - 16)};
      tests_run++;
      if (wr_q[i] !== e) begin
        tests_failed++;
        $display("FAIL full_drain_order%0d: got %h expected %h", i, wr_q[i], e);
      end
    end
    in_vblank = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_partial_vblank;
    wr_q.delete(); wr_cyc.delete();
    for (int i = 0; i < 10; i++) push_wr(12'h300 + 12'(i), 8'h30 + 8'(i));
    in_vblank = 1'b1;
    repeat (6) @(negedge clk);
    in_vblank = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (wr_q.size() != 5 || count !== 5'd5) begin
      tests_failed++;
      $display("FAIL partial_first: got %0d writes count=%0d expected 5 writes count=5", wr_q.size(), count);
    end
    in_vblank = 1'b1;
    repeat (12) @(negedge clk);
    in_vblank = 1'b0;
    tests_run++;
    if (wr_q.size() != 10 || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL partial_second: got %0d writes empty=%b expected 10 writes empty=1", wr_q.size(), empty);
    end
    for (int i = 0; i < 10 && i < wr_q.size(); i++) begin
      tests_run++;
      if (wr_q[i] !== {12'h300 + 12'(i), 8'h30 + 8'(i)}) begin
        tests_failed++;
        $display("FAIL partial_order%0d: got %h expected %h", i, wr_q[i], {12'h300 + 12'(i), 8'h30 + 8'(i)});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_drain;
    for (int i = 0; i < 4; i++) push_wr(12'h400 + 12'(i), 8'h40 + 8'(i));
    in_vblank = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (vram_write_enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_drain_active: got we=%b expected 1", vram_write_enable);
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if (vram_write_enable !== 1'b0 || count !== 5'd0) begin
      tests_failed++;
      $display("FAIL rst_async: got we=%b c=%0d expected we=0 c=0", vram_write_enable, count);
    end
    in_vblank = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      tests_failed++;
      $display("FAIL rst_release: got e=%b c=%0d expected e=1 c=0", empty, count);
    end
  endtask

  task automatic test_coalesce;
    wr_q.delete(); wr_cyc.delete();
    push_wr(12'h000, 8'h0F);
    push_wr(12'h000, 8'hF0);
`ifdef VRAM_WBUF_COALESCE_EN
    tests_run++;
    if (count !== 5'd1) begin
      tests_failed++;
      $display("FAIL coalesce_count: got %0d expected 1", count);
    end
    in_vblank = 1'b1;
    repeat (6) @(negedge clk);
    in_vblank = 1'b0;
    tests_run++;
    if (wr_q.size() != 1 || wr_q[0] !== 20'h000F0) begin
      tests_failed++;
      $display("FAIL coalesce_drain: got %0d writes expected 1 write 000F0", wr_q.size());
    end
`else
    tests_run++;
    if (count !== 5'd2) begin
      tests_failed++;
      $display("FAIL nocoalesce_count: got %0d expected 2", count);
    end
    in_vblank = 1'b1;
    repeat (6) @(negedge clk);
    in_vblank = 1'b0;
    tests_run++;
    if (wr_q.size() != 2 || wr_q[0] !== 20'h0000F || wr_q[1] !== 20'h000F0) begin
      tests_failed++;
      $display("FAIL nocoalesce_drain: got %0d writes expected 0000F then 000F0", wr_q.size());
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    rst          = 1'b1;
    cpu_address  = '0;
    cpu_data     = '0;
    cpu_write    = 1'b0;
    in_vblank    = 1'b0;
    overflow_clr = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_basic;
    test_overflow;
    test_full_drain;
    test_partial_vblank;
    test_reset_mid_drain;
    test_coalesce;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
